// File: rtl/coreriscv_axi4_tl_scratchpad_manager.sv
// Uncached TileLink manager that serves Get/Put/Block/Prefetch acquires from a 64-bit scratchpad.
// Optional CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN zero-fills the memory after reset before accepting work.
module coreriscv_axi4_tl_scratchpad_manager #(
    parameter int unsigned DEPTH_BLOCKS = 64,
    parameter logic        MANAGER_ID   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        io_acquire_ready,
    input  logic        io_acquire_valid,
    input  logic [25:0] io_acquire_bits_addr_block,
    input  logic [1:0]  io_acquire_bits_client_xact_id,
    input  logic [2:0]  io_acquire_bits_addr_beat,
    input  logic        io_acquire_bits_is_builtin_type,
    input  logic [2:0]  io_acquire_bits_a_type,
    input  logic [11:0] io_acquire_bits_union,
    input  logic [63:0] io_acquire_bits_data,
    input  logic        io_grant_ready,
    output logic        io_grant_valid,
    output logic [2:0]  io_grant_bits_addr_beat,
    output logic [1:0]  io_grant_bits_client_xact_id,
    output logic        io_grant_bits_manager_xact_id,
    output logic        io_grant_bits_is_builtin_type,
    output logic [3:0]  io_grant_bits_g_type,
    output logic [63:0] io_grant_bits_data,
    output logic        io_grant_bits_manager_id
);
    localparam int unsigned IDX_W = $clog2(DEPTH_BLOCKS);
    localparam int unsigned AW    = IDX_W + 3;
    localparam int unsigned WORDS = DEPTH_BLOCKS * 8;

    localparam logic [2:0] A_GET       = 3'd0;
    localparam logic [2:0] A_GET_BLOCK = 3'd1;
    localparam logic [2:0] A_PUT       = 3'd2;
    localparam logic [2:0] A_PUT_BLOCK = 3'd3;
    localparam logic [2:0] A_PREF_R    = 3'd5;
    localparam logic [2:0] A_PREF_W    = 3'd6;

    localparam logic [3:0] G_PREFETCH_ACK = 4'd1;
    localparam logic [3:0] G_PUT_ACK      = 4'd3;
    localparam logic [3:0] G_GET_BEAT     = 4'd4;
    localparam logic [3:0] G_GET_BLOCK    = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_RESP,
        S_WR_BLOCK,
        S_ACK,
        S_INIT
    } state_e;

`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
    localparam state_e RST_STATE = S_INIT;
`else
    localparam state_e RST_STATE = S_IDLE;
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   block_q, block_d;
    logic [1:0]         xact_q, xact_d;
    logic [2:0]         atype_q, atype_d;
    logic [2:0]         beat_q, beat_d;
    logic [3:0]         gtype_q, gtype_d;
    logic [63:0]        rdata_q;
    logic [63:0]        mem_q [WORDS];

    logic               we;
    logic [AW-1:0]      waddr;
    logic [63:0]        wdata;
    logic [7:0]         wmask;
    logic               rd_en;
    logic               bad_op;
    logic               beat_err;
    logic               unused_bits;

`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
    logic [AW-1:0]      init_q, init_d;
`endif

    // Upper block bits, alloc and the reserved union bits carry no meaning here.
    assign unused_bits = ^{io_acquire_bits_addr_block, io_acquire_bits_union[11:9],
                           io_acquire_bits_union[0]};

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        xact_d   = xact_q;
        atype_d  = atype_q;
        beat_d   = beat_q;
        gtype_d  = gtype_q;
`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
        init_d   = init_q;
`endif
        we       = 1'b0;
        waddr    = {block_q, beat_q};
        wdata    = io_acquire_bits_data;
        wmask    = io_acquire_bits_union[8:1];
        rd_en    = 1'b0;
        bad_op   = 1'b0;
        beat_err = 1'b0;

        io_acquire_ready              = 1'b0;
        io_grant_valid                = 1'b0;
        io_grant_bits_addr_beat       = 3'd0;
        io_grant_bits_data            = 64'd0;
        io_grant_bits_client_xact_id  = xact_q;
        io_grant_bits_g_type          = gtype_q;
        io_grant_bits_manager_xact_id = 1'b0;
        io_grant_bits_is_builtin_type = 1'b1;
        io_grant_bits_manager_id      = MANAGER_ID;

        unique case (state_q)
            S_IDLE: begin
                io_acquire_ready = 1'b1;
                if (io_acquire_valid) begin
                    block_d = io_acquire_bits_addr_block[IDX_W-1:0];
                    xact_d  = io_acquire_bits_client_xact_id;
                    atype_d = io_acquire_bits_a_type;
                    beat_d  = io_acquire_bits_addr_beat;
                    gtype_d = G_PUT_ACK;
                    state_d = S_ACK;
                    waddr   = {io_acquire_bits_addr_block[IDX_W-1:0], io_acquire_bits_addr_beat};
                    if (!io_acquire_bits_is_builtin_type) begin
                        bad_op = 1'b1;
                    end else begin
                        case (io_acquire_bits_a_type)
                            A_GET: begin
                                gtype_d = G_GET_BEAT;
                                state_d = S_RD_ISSUE;
                            end
                            A_GET_BLOCK: begin
                                beat_d  = 3'd0;
                                gtype_d = G_GET_BLOCK;
                                state_d = S_RD_ISSUE;
                            end
                            A_PUT: begin
                                we = 1'b1;
                            end
                            A_PUT_BLOCK: begin
                                we      = 1'b1;
                                beat_d  = 3'd1;
                                state_d = S_WR_BLOCK;
                            end
                            A_PREF_R, A_PREF_W: begin
                                gtype_d = G_PREFETCH_ACK;
                            end
                            default: begin
                                bad_op = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_RD_ISSUE: begin
                rd_en   = 1'b1;
                state_d = S_RD_RESP;
            end
            S_RD_RESP: begin
                io_grant_valid          = 1'b1;
                io_grant_bits_addr_beat = beat_q;
                io_grant_bits_data      = rdata_q;
                if (io_grant_ready) begin
                    if (atype_q == A_GET_BLOCK && beat_q != 3'd7) begin
                        beat_d  = beat_q + 3'd1;
                        state_d = S_RD_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WR_BLOCK: begin
                io_acquire_ready = 1'b1;
                if (io_acquire_valid) begin
                    // Out-of-order beats are flagged but still land where the client asked.
                    we       = 1'b1;
                    waddr    = {block_q, io_acquire_bits_addr_beat};
                    beat_err = (io_acquire_bits_addr_beat != beat_q);
                    beat_d   = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                io_grant_valid = 1'b1;
                if (io_grant_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
            S_INIT: begin
                we      = 1'b1;
                waddr   = init_q;
                wdata   = 64'd0;
                wmask   = 8'hFF;
                init_d  = init_q + 1'b1;
                if (init_q == AW'(WORDS - 1)) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset aborts any transaction: hold the bus quiet and block stray writes.
        if (reset) begin
            io_acquire_ready             = 1'b0;
            io_grant_valid               = 1'b0;
            io_grant_bits_addr_beat      = 3'd0;
            io_grant_bits_data           = 64'd0;
            io_grant_bits_client_xact_id = 2'd0;
            io_grant_bits_g_type         = 4'd0;
            we                           = 1'b0;
            rd_en                        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            block_q <= '0;
            xact_q  <= 2'd0;
            atype_q <= 3'd0;
            beat_q  <= 3'd0;
            gtype_q <= 4'd0;
`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
            init_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            xact_q  <= xact_d;
            atype_q <= atype_d;
            beat_q  <= beat_d;
            gtype_q <= gtype_d;
`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
            init_q  <= init_d;
`endif
        end
    end

    // Read data is captured once per beat so it holds steady while the grant stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) begin
                    mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata_q <= mem_q[{block_q, beat_q}];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!bad_op) else $error("scratchpad: unsupported acquire type");
            assert (!beat_err) else $error("scratchpad: PutBlock beat out of order");
        end
    end
`endif

endmodule

// File: tb/tb_coreriscv_axi4_tl_scratchpad_manager.sv
// Scoreboard bench for the scratchpad manager: stimulus pushes expected grants, a monitor pops on grant fire.
module tb_coreriscv_axi4_tl_scratchpad_manager;
`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
    localparam int unsigned DEPTH = 2;
    localparam logic [63:0] POST_RST_B5B1 = 64'h0;
`else
    localparam int unsigned DEPTH = 64;
    localparam logic [63:0] POST_RST_B5B1 = 64'h0101;
`endif

    typedef struct packed {
        logic [3:0]  g;
        logic [2:0]  beat;
        logic [1:0]  xid;
        logic [63:0] data;
    } gnt_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        acq_ready, acq_valid = 1'b0;
    logic [25:0] acq_block = '0;
    logic [1:0]  acq_xid = '0;
    logic [2:0]  acq_beat = '0;
    logic        acq_builtin = 1'b1;
    logic [2:0]  acq_type = '0;
    logic [11:0] acq_union = '0;
    logic [63:0] acq_data = '0;
    logic        gnt_ready = 1'b1;
    logic        gnt_valid;
    logic [2:0]  gnt_beat;
    logic [1:0]  gnt_xid;
    logic        gnt_mxid, gnt_builtin, gnt_mid;
    logic [3:0]  gnt_type;
    logic [63:0] gnt_data;

    gnt_t sb[$];
    int   nchk = 0;
    int   npass = 0;

    always #5 clk = ~clk;

    coreriscv_axi4_tl_scratchpad_manager #(.DEPTH_BLOCKS(DEPTH), .MANAGER_ID(1'b1)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .io_acquire_ready               (acq_ready),
        .io_acquire_valid               (acq_valid),
        .io_acquire_bits_addr_block     (acq_block),
        .io_acquire_bits_client_xact_id (acq_xid),
        .io_acquire_bits_addr_beat      (acq_beat),
        .io_acquire_bits_is_builtin_type(acq_builtin),
        .io_acquire_bits_a_type         (acq_type),
        .io_acquire_bits_union          (acq_union),
        .io_acquire_bits_data           (acq_data),
        .io_grant_ready                 (gnt_ready),
        .io_grant_valid                 (gnt_valid),
        .io_grant_bits_addr_beat        (gnt_beat),
        .io_grant_bits_client_xact_id   (gnt_xid),
        .io_grant_bits_manager_xact_id  (gnt_mxid),
        .io_grant_bits_is_builtin_type  (gnt_builtin),
        .io_grant_bits_g_type           (gnt_type),
        .io_grant_bits_data             (gnt_data),
        .io_grant_bits_manager_id       (gnt_mid)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_gnt(input logic [3:0] g, input logic [2:0] beat, input logic [1:0] xid,
                              input logic [63:0] d);
        gnt_t e;
        e = '{g: g, beat: beat, xid: xid, data: d};
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] at, input logic [25:0] blk, input logic [2:0] beat,
                        input logic [1:0] xid, input logic [63:0] d, input logic [7:0] m);
        int n;
        acq_type  = at;
        acq_block = blk;
        acq_beat  = beat;
        acq_xid   = xid;
        acq_data  = d;
        acq_union = {3'b000, m, 1'b0};
        acq_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!acq_ready && n < 100);
        if (!acq_ready) chk("acquire_timeout", 80'd0, 80'd1);
        @(posedge clk);
        #1 acq_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 80'(sb.size()), 80'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant fire is checked against the oldest expected grant.
    initial begin
        gnt_t e;
        forever begin
            @(negedge clk);
            if (!reset && gnt_valid && gnt_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", {4'(gnt_type), 3'(gnt_beat), 64'(gnt_data)}, 80'd0);
                end else begin
                    e = sb.pop_front();
                    chk("grant", {gnt_type, gnt_beat, gnt_xid, gnt_data, gnt_mxid, gnt_builtin, gnt_mid},
                        {e.g, e.beat, e.xid, e.data, 1'b0, 1'b1, 1'b1});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic v1, v2;
        int   n, lows;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_handshake", {gnt_valid, acq_ready}, 2'b00);
        chk("reset_grant_bits", {gnt_type, gnt_beat, gnt_xid, gnt_data, gnt_mxid, gnt_builtin, gnt_mid},
            {4'd0, 3'd0, 2'd0, 64'd0, 1'b0, 1'b1, 1'b1});
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
        lows = 0;
        for (int i = 0; i < DEPTH * 8; i++) begin
            @(negedge clk);
            if (!acq_ready) lows++;
        end
        chk("init_ready_low_cycles", 80'(lows), 80'(DEPTH * 8));
        @(negedge clk);
        chk("init_ready_high", 80'(acq_ready), 80'd1);
        @(posedge clk);
        #1;
        expect_gnt(4'd4, 3'd5, 2'd0, 64'd0);
        send(3'd0, 26'd0, 3'd5, 2'd0, 64'd0, 8'h00);
        drain();
`else
        @(negedge clk);
        chk("ready_after_reset", 80'(acq_ready), 80'd1);
        @(posedge clk);
        #1;
`endif

        // Full put then masked put, then Get with latency check.
        expect_gnt(4'd3, 3'd0, 2'd1, 64'd0);
        send(3'd2, 26'd3, 3'd2, 2'd1, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
        drain();
        expect_gnt(4'd3, 3'd0, 2'd3, 64'd0);
        send(3'd2, 26'd3, 3'd2, 2'd3, 64'h1122_3344_5566_7788, 8'h0F);
        drain();
        expect_gnt(4'd4, 3'd2, 2'd2, 64'hA5A5_A5A5_5566_7788);
        send(3'd0, 26'd3, 3'd2, 2'd2, 64'd0, 8'h00);
        @(negedge clk);
        v1 = gnt_valid;
        @(negedge clk);
        v2 = gnt_valid;
        chk("get_latency", {v1, v2}, 2'b01);
        drain();

        // PutBlock block 5, one ack after the last beat.
        expect_gnt(4'd3, 3'd0, 2'd0, 64'd0);
        for (int k = 0; k < 8; k++) send(3'd3, 26'd5, 3'(k), 2'd0, 64'(k * 64'h0101), 8'hFF);
        drain();

        // GetBlock block 5 with a 5-cycle stall on beat 3.
        for (int k = 0; k < 8; k++) expect_gnt(4'd5, 3'(k), 2'd1, 64'(k * 64'h0101));
        send(3'd1, 26'd5, 3'd0, 2'd1, 64'd0, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt_valid && gnt_beat == 3'd2) && n < 100);
        chk("stall_reach_beat2", 80'(gnt_beat), 80'd2);
        @(posedge clk);
        #1 gnt_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {gnt_valid, gnt_beat, gnt_data, acq_ready}, {1'b1, 3'd3, 64'h0303, 1'b0});
        end
        @(posedge clk);
        #1 gnt_ready = 1'b1;
        drain();

        // Prefetch, then confirm memory untouched.
        expect_gnt(4'd1, 3'd0, 2'd2, 64'd0);
        send(3'd5, 26'd3, 3'd2, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        drain();
        expect_gnt(4'd4, 3'd2, 2'd0, 64'hA5A5_A5A5_5566_7788);
        send(3'd0, 26'd3, 3'd2, 2'd0, 64'd0, 8'h00);
        drain();

        // Reset during PutBlock after beat 3: no grant, then a Get works.
        for (int k = 0; k < 4; k++) send(3'd3, 26'd6, 3'(k), 2'd2, 64'hDEAD_0000 + 64'(k), 8'hFF);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
`ifdef CORERISCV_AXI4_SCRATCHPAD_ZERO_INIT_EN
        @(negedge clk);
        chk("ready_low_after_midreset", 80'(acq_ready), 80'd0);
`else
        @(negedge clk);
        chk("ready_after_midreset", 80'(acq_ready), 80'd1);
`endif
        @(posedge clk);
        #1;
        expect_gnt(4'd4, 3'd1, 2'd3, POST_RST_B5B1);
        send(3'd0, 26'd5, 3'd1, 2'd3, 64'd0, 8'h00);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
